// File: rtl/multicast_tx.sv
// multicast_tx
// Source end of the PE multicast bus. Values arriving from the global buffer
// read port are held in a small skid FIFO. Each value is stamped with a
// destination tag and driven onto the bus. Tags rotate round-robin over the
// window base..base+span. The window may wrap through zero. After the
// programmed number of values has been transferred, done pulses for one cycle.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   cfg_start     single-cycle pulse; latches config and starts a frame (IDLE only)
//   cfg_tag_base  first destination tag
//   cfg_tag_span  window size minus one
//   cfg_total     number of values in the frame
//   in_val        upstream data
//   in_valid      upstream data valid
//   in_ready      upstream value accepted this cycle
//   bus_val       value on the multicast bus (0 when bus_valid=0)
//   bus_tag       destination tag (0 when bus_valid=0)
//   bus_valid     bus word valid
//   bus_ready     receiving network accepted the word
//   busy          frame in progress
//   done          one-cycle pulse after the last bus transfer of a frame
module multicast_tx #(
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [TAG_W-1:0]  cfg_tag_base,
    input  logic [TAG_W-1:0]  cfg_tag_span,
    input  logic [15:0]       cfg_total,
    input  logic [DATA_W-1:0] in_val,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_val,
    output logic [TAG_W-1:0]  bus_tag,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0]  base_r;
    logic [TAG_W-1:0]  span_r;
    logic [15:0]       total_r;
    logic [15:0]       in_cnt;
    logic [15:0]       out_cnt;
    logic [TAG_W-1:0]  tag_ptr;
    logic              done_r;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic fifo_full, fifo_empty;
    logic push, pop, last_pop, finish;
    logic [TAG_W-1:0] tag_end;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    // No pass-through: a full FIFO refuses input even if it pops this cycle,
    // which keeps bus_ready out of the in_ready path.
    assign in_ready  = (state == RUN) && !fifo_full && (in_cnt < total_r);
    assign bus_valid = (state == RUN) && !fifo_empty;
    assign bus_val   = bus_valid ? mem[rd_ptr] : '0;
    assign bus_tag   = bus_valid ? tag_ptr : '0;
    assign busy      = (state == RUN);
    assign done      = done_r;

    assign push     = in_valid && in_ready;
    assign pop      = bus_valid && bus_ready;
    assign last_pop = pop && ((out_cnt + 16'd1) == total_r);
    // A zero-length frame finishes on its first RUN cycle with no transfers.
    assign finish   = (state == RUN) && ((total_r == 16'd0) || last_pop);

    // Upper end of the tag window; modular add lets the window wrap through 0.
    assign tag_end  = base_r + span_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cfg_start) state_nxt = RUN;
            RUN:  if (finish)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_r  <= '0;
            span_r  <= '0;
            total_r <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            tag_ptr <= '0;
            done_r  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            done_r <= finish;
            if (state == IDLE) begin
                if (cfg_start) begin
                    base_r  <= cfg_tag_base;
                    span_r  <= cfg_tag_span;
                    total_r <= cfg_total;
                    tag_ptr <= cfg_tag_base;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    count   <= '0;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    in_cnt <= in_cnt + 16'd1;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    out_cnt <= out_cnt + 16'd1;
                    tag_ptr <= (tag_ptr == tag_end) ? base_r : tag_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                // End of frame returns the rotation to the window start.
                if (finish) tag_ptr <= base_r;
            end
        end
    end

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_val;
    end

endmodule

// File: tb/tb_multicast_tx.sv
module tb_multicast_tx;

    localparam int DATA_W     = 16;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start;
    logic [TAG_W-1:0]  cfg_tag_base;
    logic [TAG_W-1:0]  cfg_tag_span;
    logic [15:0]       cfg_total;
    logic [DATA_W-1:0] in_val;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] bus_val;
    logic [TAG_W-1:0]  bus_tag;
    logic              bus_valid;
    logic              bus_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    multicast_tx #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_tag_base(cfg_tag_base),
        .cfg_tag_span(cfg_tag_span), .cfg_total(cfg_total),
        .in_val(in_val), .in_valid(in_valid), .in_ready(in_ready),
        .bus_val(bus_val), .bus_tag(bus_tag), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame with in_valid held high. bus_ready is low for the first
    // 'hold' cycles; a cfg_start is injected at cycle 'inj' (negative: none).
    task automatic run_frame(input int n, input int fv, input int base, input int span,
                             input int hold, input int inj);
        int in_i;
        int out_i;
        int cyc;
        logic [TAG_W-1:0] etag;
        @(negedge clk);
        cfg_tag_base = base[TAG_W-1:0];
        cfg_tag_span = span[TAG_W-1:0];
        cfg_total    = n[15:0];
        cfg_start    = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        in_i = 0; out_i = 0; cyc = 0;
        while (out_i < n && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            cfg_start = (cyc == inj);
            if (cyc == inj) begin
                cfg_tag_base = cfg_tag_base + 4'd7;
                cfg_total    = 16'd1;
            end
            in_valid  = 1'b1;
            in_val    = 16'(fv + in_i);
            bus_ready = (cyc >= hold);
            if (hold > 0 && cyc == hold - 1) begin
                chk("bp_accepts", in_i, FIFO_DEPTH);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_valid", {31'd0, bus_valid}, 32'd1);
                chk("bp_val_stable", {16'd0, bus_val}, 32'(fv));
                chk("bp_tag_stable", {28'd0, bus_tag}, 32'(base));
            end
            if (done) chk("done_early", {31'd0, done}, 32'd0);
            if (in_ready) in_i++;
            if (bus_valid && bus_ready) begin
                etag = 4'(base + out_i % (span + 1));
                chk($sformatf("val[%0d]", out_i), {16'd0, bus_val}, 32'(fv + out_i));
                chk($sformatf("tag[%0d]", out_i), {28'd0, bus_tag}, {28'd0, etag});
                out_i++;
            end
            cyc++;
        end
        chk("frame_complete", out_i, n);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("valid_end", {31'd0, bus_valid}, 32'd0);
        chk("val_zero_end", {16'd0, bus_val}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        chk("accepted_total", in_i, n);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_tag_base = '0; cfg_tag_span = '0;
        cfg_total = '0; in_val = '0; in_valid = 1'b0; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_val", {16'd0, bus_val}, 32'd0);
        chk("rst_bus_tag", {28'd0, bus_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Basic rotation with an ignored cfg_start mid-frame.
        run_frame(6, 10, 2, 2, 0, 2);
        // Tag window wrapping through zero.
        run_frame(5, 40, 14, 3, 0, -1);
        // Backpressure for 8 cycles with continuous input.
        run_frame(8, 200, 1, 3, 8, -1);
        // Frame limit with in_valid held high.
        run_frame(3, 300, 7, 0, 0, -1);

        // Zero-length frame.
        @(negedge clk);
        cfg_tag_base = 4'd3; cfg_tag_span = 4'd1; cfg_total = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("z_busy", {31'd0, busy}, 32'd1);
        chk("z_valid", {31'd0, bus_valid}, 32'd0);
        chk("z_in_ready", {31'd0, in_ready}, 32'd0);
        chk("z_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy_end", {31'd0, busy}, 32'd0);
        chk("z_valid_end", {31'd0, bus_valid}, 32'd0);
        @(negedge clk);
        chk("z_done_clear", {31'd0, done}, 32'd0);

        // Mid-frame reset with two words buffered.
        cfg_tag_base = 4'd5; cfg_tag_span = 4'd1; cfg_total = 16'd6; cfg_start = 1'b1;
        bus_ready = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0; in_valid = 1'b1; in_val = 16'd100;
        @(negedge clk);
        in_val = 16'd101;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_valid", {31'd0, bus_valid}, 32'd1);
        chk("mr_head", {16'd0, bus_val}, 32'd100);
        chk("mr_tag", {28'd0, bus_tag}, 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("mr_bus_val", {16'd0, bus_val}, 32'd0);
        chk("mr_bus_tag", {28'd0, bus_tag}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("mr_no_done", {31'd0, done}, 32'd0);
        chk("mr_still_empty", {31'd0, bus_valid}, 32'd0);
        run_frame(4, 500, 5, 1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicast_tx.md
# multicast_tx

Source end of the PE multicast bus: takes an upstream stream of 16-bit values, buffers them, stamps each one with a destination tag, and drives the tagged value onto the bus. Every PE compares the tag against its configured ID to pick up its data. Tags rotate round-robin over a programmed ID window, and a programmed frame length sets how many values are issued before the block reports done. It sits between the global buffer read port and the row of PE multicast receivers.

## Interface
- DATA_W, 16, value width on the upstream input and on the bus
- TAG_W, 4, tag/ID width; must match the PE ID width
- FIFO_DEPTH, 4, skid buffer entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- cfg_start  in  1  single-cycle pulse; latches config and starts a frame (honoured in IDLE only)
- cfg_tag_base  in  TAG_W  first destination tag
- cfg_tag_span  in  TAG_W  window size minus one; tags cycle base..base+span
- cfg_total  in  16  number of values in the frame
- in_val  in  DATA_W  upstream data
- in_valid  in  1  upstream data valid
- in_ready  out  1  block accepts in_val this cycle
- bus_val  out  DATA_W  value on multicast bus
- bus_tag  out  TAG_W  destination tag
- bus_valid  out  1  bus word valid
- bus_ready  in  1  receiving network accepted the word (AND of matched PEs' readiness)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last bus transfer of frame

## Operation
- States: IDLE, RUN.
- IDLE: in_ready=0, bus_valid=0, busy=0. On cfg_start:
  - latch base, span, total;
  - tag_ptr←base;
  - clear in_cnt and out_cnt;
  - go to RUN.
- If cfg_total=0 at start: go to RUN, then pulse done on the next cycle and return to IDLE with no transfers.
- RUN: busy=1; cfg_start ignored.
  - Upstream accept: in_ready = !fifo_full && (in_cnt < total). A transfer (in_valid && in_ready) pushes the value and increments in_cnt.
  - Bus side: bus_valid = !fifo_empty. bus_val = FIFO head. bus_tag = tag_ptr.
  - Bus transfer (bus_valid && bus_ready): pops the head and increments out_cnt.
  - After each bus transfer, tag_ptr advances: if tag_ptr == base+span (mod 2^TAG_W), tag_ptr←base; otherwise tag_ptr←tag_ptr+1 (mod 2^TAG_W). The window may therefore wrap through 0.
- Stall: while bus_valid && !bus_ready, bus_val and bus_tag hold stable. bus_valid never deasserts without a transfer.
- Push and pop in the same cycle are both performed; occupancy is unchanged. When the FIFO is full, in_ready=0 even if a pop occurs that cycle (no pass-through).
- When the bus transfer making out_cnt == total occurs: the next cycle pulses done=1, busy=0, state←IDLE, tag_ptr←base.
- bus_val and bus_tag read 0 whenever bus_valid=0.
- Counters are 16-bit and never exceed total.

## Timing
- Reset values (rst_n low at a clk edge): state IDLE, FIFO empty, in_cnt=out_cnt=0, tag_ptr=0, in_ready=0, bus_valid=0, bus_val=0, bus_tag=0, busy=0, done=0.
- Reset mid-frame: buffered words are discarded and no done pulse is issued.
- cfg_start at edge N: busy=1 and in_ready may be 1 from cycle N+1.
- Latency: upstream accepted at edge N with FIFO empty gives bus_valid=1 with that value from cycle N+1.
- Throughput: 1 word/cycle sustained when in_valid=bus_ready=1.
- done: asserted the cycle after the final bus transfer, for exactly one cycle. A new cfg_start is accepted in that same done cycle's following cycle (IDLE).
- All outputs are driven from registers or FIFO state; there is no combinational path from bus_ready to in_ready.

## Test plan
- Basic rotation: base=2, span=2, total=6, values 10..15, bus_ready=1 → bus tags 2,3,4,2,3,4 with values 10..15; done pulses one cycle after the 6th transfer.
- Tag wrap: base=14, span=3, total=5 → tags 14,15,0,1,14.
- Backpressure: bus_ready=0 for 8 cycles with continuous input → in_ready drops after FIFO_DEPTH accepts, bus_val/bus_tag stable; on release, all words arrive in order with no loss or duplication.
- Frame limit: total=3 with in_valid held high → exactly 3 accepted, in_ready=0 afterwards, busy falls with done.
- Edge configs: total=0 → done pulse one cycle after start, no bus_valid. cfg_start during RUN → ignored, tags unchanged.
- Mid-frame reset: assert rst_n=0 with 2 words buffered → next cycle all outputs at reset values, no done; a fresh frame then starts from base.
